// File: rtl/puf_eval_scheduler.sv
// puf_eval_scheduler: round-robin front end for a single 16-bit RO PUF.
// Each accepted challenge is evaluated NUM_EVAL times with a rest gap in
// between; the returned response is the bitwise majority of those
// evaluations, flagged unstable if any evaluation disagreed with the first,
// or flagged as an error (data forced to zero) if the PUF stopped answering.
module puf_eval_scheduler #(
    parameter int unsigned NUM_EVAL       = 3,
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [3:0]  ACT_PATTERN    = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_challenge,
    output logic [1:0]  req_ready,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_unstable,
    output logic        rsp_err,
    output logic [15:0] puf_challenge,
    output logic [3:0]  puf_activation,
    output logic        puf_generated,
    input  logic [15:0] puf_response,
    input  logic        puf_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       EVAL_N   = 3'(NUM_EVAL);
    localparam logic [2:0]       HALF     = 3'(NUM_EVAL / 2);

    logic [1:0]            state;
    logic                  last_grant;
    logic                  id_q;
    logic [2:0]            eval_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic [GAP_W-1:0]      gap_cnt;
    logic [15:0][2:0]      ones;
    logic [15:0]           first_rsp;
    logic                  unstable_q;
    logic                  err_q;

    logic                  grant_any;
    logic                  grant_id;
    logic                  accept;
    logic [15:0]           grant_chal;
    logic [15:0]           vote;

    // Round-robin winner: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned and no latch is inferred.
        grant_any = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01:   grant_any = 1'b1;
            2'b10: begin
                grant_any = 1'b1;
                grant_id  = 1'b1;
            end
            2'b11: begin
                grant_any = 1'b1;
                grant_id  = ~last_grant;
            end
            default: ;
        endcase
    end

    assign req_ready  = (state == ST_IDLE && grant_any && !rst)
                        ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign accept     = |(req_valid & req_ready);
    assign grant_chal = grant_id ? req_challenge[31:16] : req_challenge[15:0];

    // Bitwise majority over the per-bit ones counters.
    always_comb begin
        vote = '0;
        for (int b = 0; b < 16; b++) begin
            vote[b] = (ones[b] > HALF);
        end
    end

    // Scheduler state machine, PUF drive and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            last_grant     <= 1'b1;
            id_q           <= 1'b0;
            eval_cnt       <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            // NOTE: the vote counters are a few flops rather than a RAM, so they are reset like any other state.
            ones           <= '0;
            first_rsp      <= '0;
            unstable_q     <= 1'b0;
            err_q          <= 1'b0;
            puf_generated  <= 1'b0;
            puf_challenge  <= '0;
            puf_activation <= '0;
            rsp_valid      <= 1'b0;
            rsp_id         <= 1'b0;
            rsp_data       <= '0;
            rsp_unstable   <= 1'b0;
            rsp_err        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q           <= grant_id;
                        last_grant     <= grant_id;
                        eval_cnt       <= '0;
                        tmo_cnt        <= '0;
                        ones           <= '0;
                        first_rsp      <= '0;
                        unstable_q     <= 1'b0;
                        err_q          <= 1'b0;
                        puf_challenge  <= grant_chal;
                        puf_activation <= ACT_PATTERN;
                        puf_generated  <= 1'b1;
                        state          <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    if (puf_ready) begin
                        for (int b = 0; b < 16; b++) begin
                            ones[b] <= ones[b] + {2'b00, puf_response[b]};
                        end
                        if (eval_cnt == 3'd0) begin
                            first_rsp <= puf_response;
                        end else begin
                            unstable_q <= unstable_q | (|(puf_response ^ first_rsp));
                        end
                        eval_cnt      <= eval_cnt + 3'd1;
                        tmo_cnt       <= '0;
                        gap_cnt       <= '0;
                        puf_generated <= 1'b0;
                        state         <= ST_GAP;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // PUF never answered: abandon the remaining evaluations.
                        err_q         <= 1'b1;
                        eval_cnt      <= EVAL_N;
                        tmo_cnt       <= '0;
                        gap_cnt       <= '0;
                        puf_generated <= 1'b0;
                        state         <= ST_GAP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        if (eval_cnt < EVAL_N && !err_q) begin
                            puf_generated <= 1'b1;
                            state         <= ST_RUN;
                        end else begin
                            rsp_valid    <= 1'b1;
                            rsp_id       <= id_q;
                            rsp_data     <= err_q ? 16'h0000 : vote;
                            rsp_unstable <= err_q ? 1'b0 : unstable_q;
                            rsp_err      <= err_q;
                            state        <= ST_RESP;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_eval_scheduler.sv
// tb_puf_eval_scheduler: directed and randomized checks of the PUF scheduler
// against a transaction-level model (arbitration order, majority vote,
// instability, timeout, PUF drive timing, response backpressure, reset).
module tb_puf_eval_scheduler;

    localparam int NE      = 3;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [31:0] req_challenge;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_unstable;
    logic        rsp_err;
    logic [15:0] puf_challenge;
    logic [3:0]  puf_activation;
    logic        puf_generated;
    logic [15:0] puf_response;
    logic        puf_ready;

    int n_vec  = 0;
    int n_fail = 0;

    // PUF model and drive monitor state
    logic [15:0] puf_q[$];
    bit          puf_dead = 1'b0;
    int          puf_lat  = 20;
    int          run_cnt;
    logic        gen_prev;
    int          low_run;
    bit          had_high;
    int          gaps[$];
    logic [15:0] chal_seen[$];

    // Reference model state
    int          last_grant_m;
    logic [15:0] ev [NE];

    puf_eval_scheduler #(
        .NUM_EVAL(NE), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .ACT_PATTERN(4'b0011)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_challenge(req_challenge), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_unstable(rsp_unstable), .rsp_err(rsp_err),
        .puf_challenge(puf_challenge), .puf_activation(puf_activation),
        .puf_generated(puf_generated), .puf_response(puf_response), .puf_ready(puf_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return 1 - last;
    endfunction

    // PUF behaviour (ready a fixed latency after generated rises, cleared when
    // generated drops) plus a monitor of gap lengths and per-evaluation challenges.
    initial begin
        puf_ready    = 1'b0;
        puf_response = 16'h0000;
        run_cnt      = 0;
        gen_prev     = 1'b0;
        low_run      = 0;
        had_high     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || rsp_valid) begin
                had_high = 1'b0;
                low_run  = 0;
            end
            if (puf_generated === 1'b1) begin
                if (!gen_prev) begin
                    chal_seen.push_back(puf_challenge);
                    if (had_high) gaps.push_back(low_run);
                end
                low_run  = 0;
                had_high = 1'b1;
                if (!puf_ready) begin
                    run_cnt++;
                    if (run_cnt >= puf_lat && !puf_dead) begin
                        puf_ready    = 1'b1;
                        puf_response = (puf_q.size() > 0) ? puf_q.pop_front() : 16'h0000;
                    end
                end
            end else begin
                puf_ready = 1'b0;
                run_cnt   = 0;
                if (had_high) low_run++;
            end
            gen_prev = (puf_generated === 1'b1);
        end
    end

    // One full transaction from the IDLE-side negedge through the response handshake.
    task automatic do_txn(input logic [1:0] valid, input logic [15:0] c0, input logic [15:0] c1,
                          input bit dead, input int lat, input int bp, input bit hold);
        int          exp_id;
        logic [15:0] exp_chal;
        logic [15:0] exp_data;
        logic        exp_unst;
        logic        exp_err;
        int          ones;
        int          k;
        int          t;
        int          bad;
        logic [1:0]  busy_rdy;

        exp_id   = pick(valid, last_grant_m);
        exp_chal = (exp_id == 1) ? c1 : c0;
        exp_data = 16'h0000;
        exp_unst = 1'b0;
        exp_err  = dead;
        if (!dead) begin
            for (int b = 0; b < 16; b++) begin
                ones = 0;
                for (int e = 0; e < NE; e++) ones += int'(ev[e][b]);
                exp_data[b] = (2 * ones > NE);
            end
            for (int e = 1; e < NE; e++) if (ev[e] != ev[0]) exp_unst = 1'b1;
        end

        puf_q.delete();
        for (int e = 0; e < NE; e++) puf_q.push_back(ev[e]);
        puf_dead = dead;
        puf_lat  = lat;
        gaps.delete();
        chal_seen.delete();

        req_challenge = {c1, c0};
        req_valid     = valid;
        #1;
        k = 0;
        while (req_ready == 2'b00 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_grant", {30'd0, req_ready}, (exp_id == 1) ? 32'd2 : 32'd1);
        last_grant_m = exp_id;

        @(negedge clk);
        if (!hold) req_valid = 2'b00;
        check("puf_generated_on", {31'd0, puf_generated}, 32'd1);
        check("puf_challenge", {16'd0, puf_challenge}, {16'd0, exp_chal});
        check("puf_activation", {28'd0, puf_activation}, 32'd3);

        t        = 0;
        busy_rdy = 2'b00;
        while (rsp_valid !== 1'b1 && t < 6000) begin
            busy_rdy |= req_ready;
            @(negedge clk);
            t++;
        end
        check("rsp_valid_wait", {31'd0, rsp_valid}, 32'd1);
        check("req_ready_busy", {30'd0, busy_rdy}, 32'd0);
        if (dead) check("timeout_latency", t, TIMEOUT + GAP);
        check("rsp_id", {31'd0, rsp_id}, exp_id);
        check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_data});
        check("rsp_unstable", {31'd0, rsp_unstable}, {31'd0, exp_unst});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check("eval_count", chal_seen.size(), dead ? 1 : NE);
        foreach (chal_seen[i]) check("puf_challenge_eval", {16'd0, chal_seen[i]}, {16'd0, exp_chal});
        check("gap_count", gaps.size(), dead ? 0 : NE - 1);
        foreach (gaps[i]) check("gap_len", gaps[i], GAP);

        bad = 0;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(exp_id) || rsp_data !== exp_data ||
                rsp_unstable !== exp_unst || rsp_err !== exp_err || req_ready !== 2'b00)
                bad++;
        end
        if (bp > 0) check("rsp_hold_stable", bad, 0);

        rsp_ready = 1'b1;
        #1;
        check("req_ready_at_handshake", {30'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        logic [1:0]  rv;

        rst           = 1'b0;
        req_valid     = 2'b11;
        req_challenge = 32'hDEAD_BEEF;
        rsp_ready     = 1'b0;
        last_grant_m  = 1;
        #1 rst = 1'b1;
        #2;
        check("reset_puf_generated", {31'd0, puf_generated}, 32'd0);
        check("reset_puf_challenge", {16'd0, puf_challenge}, 32'd0);
        check("reset_puf_activation", {28'd0, puf_activation}, 32'd0);
        check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        check("reset_req_ready", {30'd0, req_ready}, 32'd0);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Stable response from requester 0
        ev[0] = 16'h00A5; ev[1] = 16'h00A5; ev[2] = 16'h00A5;
        do_txn(2'b01, 16'h1234, 16'h0000, 1'b0, 20, 0, 1'b0);

        // Majority vote with one dissenting evaluation
        ev[0] = 16'h00F0; ev[1] = 16'h00F1; ev[2] = 16'h00F0;
        do_txn(2'b01, 16'h5555, 16'h0000, 1'b0, 7, 0, 1'b0);

        // PUF never answers
        do_txn(2'b10, 16'h0000, 16'hBEEF, 1'b1, 20, 0, 1'b0);

        // Both requesters held valid: grants alternate
        ev[0] = 16'h0F0F; ev[1] = 16'h0F0F; ev[2] = 16'h0F0F;
        for (int i = 0; i < 4; i++) do_txn(2'b11, 16'h1111, 16'h2222, 1'b0, 3, 0, 1'b1);

        // Response backpressure with both requesters waiting
        ev[0] = 16'h8001; ev[1] = 16'h8001; ev[2] = 16'hC001;
        do_txn(2'b11, 16'h3333, 16'h4444, 1'b0, 5, 10, 1'b0);

        // Reset while the PUF is being evaluated
        ev[0] = 16'hFFFF; ev[1] = 16'hFFFF; ev[2] = 16'hFFFF;
        puf_q.delete();
        puf_lat       = 20;
        puf_dead      = 1'b0;
        req_challenge = 32'h6666_7777;
        req_valid     = 2'b10;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (5) @(negedge clk);
        check("pre_reset_generated", {31'd0, puf_generated}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("midrun_reset_generated", {31'd0, puf_generated}, 32'd0);
        check("midrun_reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrun_reset_challenge", {16'd0, puf_challenge}, 32'd0);
        check("midrun_reset_req_ready", {30'd0, req_ready}, 32'd0);
        repeat (3) @(negedge clk);
        rst          = 1'b0;
        last_grant_m = 1;
        @(negedge clk);
        ev[0] = 16'h1357; ev[1] = 16'h1357; ev[2] = 16'h1357;
        do_txn(2'b10, 16'h0000, 16'h2468, 1'b0, 9, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 8; n++) begin
            base = 16'($urandom);
            for (int e = 0; e < NE; e++) ev[e] = base ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            rv = 2'($urandom_range(1, 3));
            do_txn(rv, 16'($urandom), 16'($urandom), 1'b0, $urandom_range(1, 25),
                   $urandom_range(0, 4), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/puf_eval_scheduler.md
Name: puf_eval_scheduler

Overview:
- Sits between two challenge requesters (e.g. authentication and key-generation engines) and the single 16-bit RO PUF.
- Arbitrates round-robin between the requesters and drives the PUF's challenge, activation and generated inputs.
- Runs NUM_EVAL repeated evaluations per challenge, with a rest gap between evaluations.
- Returns a bitwise-majority-voted response, plus instability and timeout flags, over a valid/ready response channel.

Parameters:
- NUM_EVAL, 3, evaluations per challenge; odd, 1..7.
- GAP_CYCLES, 4, cycles puf_generated is held low between evaluations; minimum 2.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for puf_ready per evaluation.
- ACT_PATTERN, 4'b0011, value driven on puf_activation (enables both ROs).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  2  per-requester request valid; bit i is requester i.
- req_challenge  input  32  bits [16i+15:16i] are requester i's challenge.
- req_ready  output  2  one-hot accept for the request; 0 while rst is high.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  1  requester index of the response.
- rsp_data  output  16  majority-voted response.
- rsp_unstable  output  1  set if any bit differed between the evaluations.
- rsp_err  output  1  set if an evaluation timed out.
- puf_challenge  output  16  challenge to the PUF.
- puf_activation  output  4  activation to the PUF.
- puf_generated  output  1  PUF evaluate/hold; low clears the PUF's ready.
- puf_response  input  16  PUF response.
- puf_ready  input  1  PUF response valid.

Behaviour:
- Reset values: all registered outputs are 0, including puf_generated, puf_challenge, puf_activation and rsp_*. State is IDLE. last_grant is 1, so requester 0 wins first. Eval count, timeout counter and vote counters are all 0.
- States: IDLE, RUN, GAP, RESP.
- IDLE:
  - Winner = the only valid requester. If both are valid, the winner is the one not equal to last_grant.
  - req_ready[winner] is asserted combinationally; a transfer occurs when req_valid and req_ready are both high.
  - On transfer: latch the challenge and id, set last_grant to the id, clear the vote counters and eval count, and go to RUN.
  - With no valid request, stay in IDLE.
- RUN:
  - puf_generated = 1, puf_challenge = the latched challenge, puf_activation = ACT_PATTERN. These are registered, so they are valid the cycle after accept.
  - The timeout counter increments every cycle.
  - On puf_ready = 1: add each bit of puf_response into its 3-bit per-bit ones counter, OR (response XOR first-eval response) into the unstable flag (ignored on eval 0), increment the eval count, and go to GAP.
  - If the timeout counter reaches TIMEOUT_CYCLES-1 without puf_ready: set err, force remaining evals to done, and go to GAP.
  - If puf_ready and timeout occur in the same cycle, puf_ready wins and no error is set.
- GAP:
  - puf_generated = 0 for exactly GAP_CYCLES cycles; the timeout counter is cleared.
  - Then go to RUN if eval count < NUM_EVAL and no err; otherwise go to RESP.
- RESP:
  - rsp_valid = 1.
  - rsp_data[b] = (ones[b] > NUM_EVAL/2). If err is set, rsp_data = 0 and rsp_unstable = 0.
  - rsp_id, rsp_unstable and rsp_err are held stable while rsp_ready is low.
  - When rsp_ready is high: go to IDLE and drop rsp_valid the next cycle. No request is accepted in that same cycle.
- req_ready is 0 in every state except IDLE.
- Minimum accept-to-rsp_valid latency = NUM_EVAL*(1 + PUF latency + GAP_CYCLES) + 1 cycles.
- Reset asserted mid-operation: all outputs go to reset values asynchronously, including puf_generated = 0. Any in-flight request is discarded and no response is produced.
- req_valid being dropped before accept is legal; the arbiter re-evaluates every cycle.

Test Plan:
- Req0 challenge 0x1234. The PUF model returns 0x00A5 three times, each 20 cycles after generated rises. Required: puf_challenge = 0x1234, rsp_id = 0, rsp_data = 0x00A5, rsp_unstable = 0, rsp_err = 0. puf_generated is low for exactly 4 cycles between evaluations.
- Majority vote: the model returns 0x00F0, 0x00F1, 0x00F0. Required: rsp_data = 0x00F0, rsp_unstable = 1.
- Timeout: puf_ready is never asserted. Required: after 4096 RUN cycles plus 4 GAP cycles, rsp_valid = 1 with rsp_err = 1 and rsp_data = 0x0000. Only one evaluation is attempted.
- Arbitration: both req_valid held high continuously with challenges 0x1111 and 0x2222. Required: grants alternate with rsp_id 0, 1, 0, 1, and puf_challenge alternates to match.
- Backpressure: rsp_ready held low for 10 cycles with req0 and req1 both valid. Required: rsp fields stay stable, req_ready = 00 throughout, and the next accept comes no earlier than 1 cycle after the response handshake.
- Reset mid-RUN: assert rst while puf_generated = 1. Required: puf_generated = 0 and rsp_valid = 0 immediately. After release, a new req1 is served correctly with rsp_id = 1.
